cifra_controle: RTL and testbench
=================================

// Module: cifra_controle
// PURPOSE
// - Sequencer for Simon128/128 encryption: accepts one 128-bit block + 128-bit key (valid/ready), drives
//   the external key-schedule instance (esquema_chave) through load/advance, applies NUM_RODADAS round functions.
// - Returns ciphertext on a valid/ready output port. Sits between the bus-side wrapper and esquema_chave.
// PARAMETERS
// - NUM_RODADAS  68  rounds per block (Simon128/128); round counter width = $clog2(NUM_RODADAS)
// PORTS
// - clk          in   1    clock
// - rst_n        in   1    reset, asynchronous, active-low
// - clear_i      in   1    synchronous abort: return to IDLE, drop current block
// - in_valid_i   in   1    input block/key valid
// - in_ready_o   out  1    controller can accept (IDLE only)
// - key_i        in   128  key; key_i[63:0] = first round key k0
// - bloco_i      in   128  plaintext; [127:64] = x, [63:0] = y
// - out_valid_o  out  1    ciphertext valid, held until accepted
// - out_ready_i  in   1    downstream accepts ciphertext
// - bloco_o      out  128  ciphertext {x,y}; stable while out_valid_o
// - ks_enable_o  out  1    to esquema_chave enable_i (0 = load/hold k0, 1 = advance one round key)
// - ks_k0_o      out  128  to esquema_chave k0_i; driven from captured key register
// - ks_kj_i      in   64   from esquema_chave kj_o; current round key
// - busy_o       out  1    1 in LOAD/RUN/DONE
// - rodada_o     out  7    current round index (0 outside RUN)
// BEHAVIOUR
// - Reset: state=IDLE; in_ready_o=1; out_valid_o=0; bloco_o=0; ks_enable_o=0; ks_k0_o=0; busy_o=0; rodada_o=0.
// - FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
//   IDLE: in_ready_o=1, ks_enable_o=0. On in_valid_i&&in_ready_o: capture key_i->key reg, bloco_i->{x,y}; go LOAD.
//   LOAD: exactly 1 cycle, ks_enable_o=0; esquema_chave loads captured key and resets z; rodada cleared; go RUN.
//   RUN: ks_enable_o=1; each cycle: x <= y ^ f(x) ^ ks_kj_i, y <= x; rodada++.
//        f(x) = (ROL1(x) & ROL8(x)) ^ ROL2(x), 64-bit rotates. After round NUM_RODADAS-1 go DONE.
//   DONE: ks_enable_o=0; out_valid_o=1, bloco_o={x,y}; on out_ready_i go IDLE (in_ready_o rises next cycle).
// - Latency: accept edge to out_valid_o = NUM_RODADAS+2 cycles (70). Min block period 71 cycles with out_ready_i=1.
// - ks_enable_o is 1 only in RUN: key schedule advances exactly NUM_RODADAS times per block; any non-RUN cycle
//   reloads it, so no stale z/key state carries between blocks.
// - in_ready_o=0 outside IDLE; in_valid_i ignored there; key_i/bloco_i need not be held after accept.
// - out_valid_o must not drop or bloco_o change before out_ready_i; out_ready_i outside DONE ignored.
// - clear_i: highest priority; any state -> IDLE next cycle, out_valid_o=0, ciphertext discarded;
//   clear_i with in_valid_i in IDLE: no accept. Key/{x,y} registers keep contents.
// - rst_n mid-operation: immediate return to reset values; no output produced.
// - Round counter never wraps: compare to NUM_RODADAS-1 in RUN, cleared in LOAD.
// STRUCTURE
// - Package cifra_pkg: state enum (IDLE, LOAD, RUN, DONE), NUM_RODADAS default, word width 64,
//   round-count width, f() rotate amounts.
// - Sub-module rodada_simon (combinational): x,y,k -> x',y'. Controller holds FSM, counter, data regs,
//   handshakes; esquema_chave instantiated by parent, not inside this block.
// TESTING
// - Known answer: key 0f0e0d0c0b0a0908_0706050403020100, bloco 63736564207372656c6c657661727420
//   -> bloco_o 49681b1e1e54fe3f65aa832af84e0bbc; out_valid_o exactly 70 cycles after accept.
// - Backpressure: out_ready_i=0 for 20 cycles in DONE -> out_valid_o/bloco_o stable, in_ready_o=0; then accept
//   -> IDLE next cycle.
// - Back-to-back: two blocks (vector above, then same key/bloco=0) with in_valid_i always 1 -> second result
//   correct (matches reference model), proves key schedule reload; ks_enable_o high exactly 68 cycles each.
// - clear_i at RUN round 30 -> IDLE next cycle, no out_valid_o; following block yields correct ciphertext.
// - rst_n low during RUN -> all outputs reset values asynchronously; post-reset known-answer passes.
// - in_valid_i pulsed while busy_o=1 with different data -> ignored; result equals first block's ciphertext.

Source files
------------

// File: rtl/cifra_pkg.sv
// Shared types and constants for the Simon128/128 encryption sequencer.
// Includes the Simon round nonlinearity f().
package cifra_pkg;

   localparam int unsigned NUM_RODADAS_DEF = 68;
   localparam int unsigned PALAVRA_W       = 64;
   localparam int unsigned RODADA_W        = $clog2(NUM_RODADAS_DEF);

   localparam int unsigned ROT_A = 1;
   localparam int unsigned ROT_B = 8;
   localparam int unsigned ROT_C = 2;

   typedef logic [PALAVRA_W-1:0] palavra_t;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} estado_e;

   typedef struct packed {
      palavra_t x;
      palavra_t y;
   } bloco_t;

   function automatic palavra_t rol(input palavra_t v, input int unsigned n);
      return (v << n) | (v >> (PALAVRA_W - n));
   endfunction

   function automatic palavra_t f_simon(input palavra_t v);
      return (rol(v, ROT_A) & rol(v, ROT_B)) ^ rol(v, ROT_C);
   endfunction

endpackage

// File: rtl/rodada_simon.sv
// One combinational Simon round: x' = y ^ f(x) ^ k, y' = x.
module rodada_simon
   import cifra_pkg::*;
(
   input  logic [PALAVRA_W-1:0] x_i,
   input  logic [PALAVRA_W-1:0] y_i,
   input  logic [PALAVRA_W-1:0] k_i,
   output logic [PALAVRA_W-1:0] x_o,
   output logic [PALAVRA_W-1:0] y_o
);

   assign x_o = y_i ^ f_simon(x_i) ^ k_i;
   assign y_o = x_i;

endmodule

// File: rtl/cifra_controle.sv
// Simon128/128 block sequencer: accepts key+block, steps the external key
// schedule through NUM_RODADAS rounds and presents the ciphertext.
module cifra_controle
   import cifra_pkg::*;
#(
   parameter int unsigned NUM_RODADAS = NUM_RODADAS_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [127:0]         key_i,
   input  logic [127:0]         bloco_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [127:0]         bloco_o,
   output logic                 ks_enable_o,
   output logic [127:0]         ks_k0_o,
   input  logic [PALAVRA_W-1:0] ks_kj_i,
   output logic                 busy_o,
   output logic [RODADA_W-1:0]  rodada_o
);

   localparam int unsigned CNT_W = $clog2(NUM_RODADAS);

   estado_e          estado_q, estado_d;
   logic [CNT_W-1:0] rodada_q, rodada_d;
   logic [127:0]     key_q, key_d;
   bloco_t           dado_q, dado_d;
   palavra_t         x_rnd, y_rnd;

   rodada_simon u_rodada (
      .x_i (dado_q.x),
      .y_i (dado_q.y),
      .k_i (ks_kj_i),
      .x_o (x_rnd),
      .y_o (y_rnd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q <= IDLE;
         rodada_q <= '0;
         key_q    <= '0;
         dado_q   <= '0;
      end else begin
         estado_q <= estado_d;
         rodada_q <= rodada_d;
         key_q    <= key_d;
         dado_q   <= dado_d;
      end
   end

   // clear_i overrides everything but leaves the data registers untouched
   always_comb begin
      estado_d = estado_q;
      rodada_d = rodada_q;
      key_d    = key_q;
      dado_d   = dado_q;
      if (clear_i) begin
         estado_d = IDLE;
      end else begin
         case (estado_q)
            IDLE: begin
               if (in_valid_i) begin
                  key_d    = key_i;
                  dado_d.x = bloco_i[127:64];
                  dado_d.y = bloco_i[63:0];
                  estado_d = LOAD;
               end
            end
            LOAD: begin
               rodada_d = '0;
               estado_d = RUN;
            end
            RUN: begin
               dado_d.x = x_rnd;
               dado_d.y = y_rnd;
               if (rodada_q == CNT_W'(NUM_RODADAS - 1)) estado_d = DONE;
               else                                     rodada_d = rodada_q + CNT_W'(1);
            end
            DONE: begin
               if (out_ready_i) estado_d = IDLE;
            end
            default: estado_d = IDLE;
         endcase
      end
   end

   // Key schedule only advances in RUN; every other cycle reloads k0.
   assign ks_enable_o = (estado_q == RUN);
   assign ks_k0_o     = key_q;
   assign in_ready_o  = (estado_q == IDLE);
   assign out_valid_o = (estado_q == DONE);
   assign busy_o      = (estado_q != IDLE);
   assign bloco_o     = dado_q;
   assign rodada_o    = (estado_q == RUN) ? RODADA_W'(rodada_q) : '0;

endmodule

// File: tb/tb_cifra_controle.sv
// Bench for cifra_controle: behavioural key schedule model plus a Simon128/128
// reference feeding a scoreboard of expected ciphertexts.
module tb_cifra_controle;

   localparam logic [63:0]  Z       = 64'h7369f885192c0ef5;
   localparam logic [63:0]  C       = 64'hFFFFFFFFFFFFFFFC;
   localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
   localparam logic [127:0] KAT_BLK = 128'h63736564207372656c6c657661727420;
   localparam logic [127:0] KAT_CT  = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         clear_i = 1'b0;
   logic         in_valid_i = 1'b0;
   logic         out_ready_i = 1'b0;
   logic [127:0] key_i = '0;
   logic [127:0] bloco_i = '0;
   logic         in_ready_o, out_valid_o, ks_enable_o, busy_o;
   logic [127:0] bloco_o, ks_k0_o;
   logic [63:0]  ks_kj_i;
   logic [6:0]   rodada_o;

   int n_cmp = 0;
   int n_err = 0;
   logic [127:0] sb[$];

   cifra_controle dut (
      .clk(clk), .rst_n(rst_n), .clear_i(clear_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .key_i(key_i), .bloco_i(bloco_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .bloco_o(bloco_o),
      .ks_enable_o(ks_enable_o), .ks_k0_o(ks_k0_o), .ks_kj_i(ks_kj_i),
      .busy_o(busy_o), .rodada_o(rodada_o)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ror(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   function automatic logic [63:0] f_ref(input logic [63:0] v);
      return (ror(v, 63) & ror(v, 56)) ^ ror(v, 62);
   endfunction

   function automatic logic [63:0] ks_step(input logic [63:0] a, input logic [63:0] b, input int i);
      return C ^ ((Z >> (i % 62)) & 64'd1) ^ a ^ ror(b, 3) ^ ror(b, 4);
   endfunction

   function automatic logic [127:0] simon_ref(input logic [127:0] k, input logic [127:0] b);
      logic [63:0] rk [0:67];
      logic [63:0] x, y, t;
      rk[0] = k[63:0];
      rk[1] = k[127:64];
      for (int i = 0; i < 66; i++) rk[i+2] = ks_step(rk[i], rk[i+1], i);
      x = b[127:64];
      y = b[63:0];
      for (int i = 0; i < 68; i++) begin
         t = x;
         x = y ^ f_ref(x) ^ rk[i];
         y = t;
      end
      return {x, y};
   endfunction

   function automatic logic [127:0] pop_exp();
      if (sb.size() == 0) return 'x;
      return sb.pop_front();
   endfunction

   // esquema_chave: enable=0 loads k0, enable=1 advances one round key
   logic [63:0] ks_a, ks_b;
   int          ks_j;
   always @(posedge clk) begin
      if (!ks_enable_o) begin
         ks_a <= ks_k0_o[63:0];
         ks_b <= ks_k0_o[127:64];
         ks_j <= 0;
      end else begin
         ks_a <= ks_b;
         ks_b <= ks_step(ks_a, ks_b, ks_j);
         ks_j <= ks_j + 1;
      end
   end
   assign ks_kj_i = ks_a;

   task automatic drive_in(input logic [127:0] k, input logic [127:0] b, output bit to);
      int n = 0;
      to = 1'b0;
      while (!in_ready_o && n < 300) begin @(negedge clk); n++; end
      if (!in_ready_o) begin to = 1'b1; return; end
      key_i = k; bloco_i = b; in_valid_i = 1'b1;
      sb.push_back(simon_ref(k, b));
      @(negedge clk);
      in_valid_i = 1'b0; key_i = '0; bloco_i = '0;
   endtask

   // cycle index counted from the handshake cycle (0) to first out_valid_o
   task automatic wait_valid(output int cyc, output int ksen, output bit to);
      cyc = 1; ksen = 0; to = 1'b0;
      while (!out_valid_o && cyc < 300) begin
         if (ks_enable_o) ksen++;
         @(negedge clk); cyc++;
      end
      if (!out_valid_o) to = 1'b1;
   endtask

   task automatic test_reset;
      @(negedge clk); @(negedge clk);
      n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
      n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
      n_cmp++; if (bloco_o !== '0) begin n_err++; $display("FAIL reset_bloco: got %h want 0", bloco_o); end
      n_cmp++; if (ks_enable_o !== 1'b0 || ks_k0_o !== '0) begin n_err++; $display("FAIL reset_ks: got en=%b k0=%h want 0/0", ks_enable_o, ks_k0_o); end
      n_cmp++; if (busy_o !== 1'b0 || rodada_o !== '0) begin n_err++; $display("FAIL reset_busy_rodada: got %b/%0d want 0/0", busy_o, rodada_o); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_kat;
      bit to; int cyc, ksen; logic [127:0] exp;
      drive_in(KAT_KEY, KAT_BLK, to);
      n_cmp++; if (to) begin n_err++; $display("FAIL kat_accept: got timeout want in_ready"); end
      wait_valid(cyc, ksen, to);
      n_cmp++; if (to || cyc != 70) begin n_err++; $display("FAIL kat_latency: got %0d want 70", cyc); end
      n_cmp++; if (ksen != 68) begin n_err++; $display("FAIL kat_ks_enable: got %0d want 68", ksen); end
      exp = pop_exp();
      n_cmp++; if (bloco_o !== exp) begin n_err++; $display("FAIL kat_model: got %h want %h", bloco_o, exp); end
      n_cmp++; if (bloco_o !== KAT_CT) begin n_err++; $display("FAIL kat_vector: got %h want %h", bloco_o, KAT_CT); end
      out_ready_i = 1'b1; @(negedge clk); out_ready_i = 1'b0;
      n_cmp++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin n_err++; $display("FAIL kat_return_idle: got rdy=%b vld=%b want 1/0", in_ready_o, out_valid_o); end
   endtask

   task automatic test_backpressure;
      bit to, stable; int cyc, ksen; logic [127:0] exp, snap;
      drive_in({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, to);
      wait_valid(cyc, ksen, to);
      n_cmp++; if (to) begin n_err++; $display("FAIL bp_timeout: got no out_valid want out_valid"); end
      exp = pop_exp(); snap = bloco_o;
      n_cmp++; if (bloco_o !== exp) begin n_err++; $display("FAIL bp_data: got %h want %h", bloco_o, exp); end
      stable = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (out_valid_o !== 1'b1 || bloco_o !== snap || in_ready_o !== 1'b0 || busy_o !== 1'b1) stable = 1'b0;
      end
      n_cmp++; if (!stable) begin n_err++; $display("FAIL bp_hold: got vld=%b rdy=%b data=%h want 1/0/%h", out_valid_o, in_ready_o, bloco_o, snap); end
      out_ready_i = 1'b1; @(negedge clk); out_ready_i = 1'b0;
      n_cmp++; if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL bp_release: got rdy=%b busy=%b want 1/0", in_ready_o, busy_o); end
   endtask

   task automatic test_back_to_back;
      int acc = 0, got = 0, cyc = 0, ksen = 0;
      int acc_cyc[2];
      bit chg = 1'b0;
      logic [127:0] exp;
      key_i = KAT_KEY; bloco_i = KAT_BLK; in_valid_i = 1'b1; out_ready_i = 1'b1;
      while (got < 2 && cyc < 400) begin
         if (chg) begin
            chg = 1'b0;
            if (acc == 1) bloco_i = '0;
            else in_valid_i = 1'b0;
         end
         if (ks_enable_o) ksen++;
         if (in_valid_i && in_ready_o) begin
            if (acc < 2) acc_cyc[acc] = cyc;
            acc++;
            sb.push_back(simon_ref(key_i, bloco_i));
            chg = 1'b1;
         end
         if (out_valid_o && out_ready_i) begin
            exp = pop_exp();
            n_cmp++; if (bloco_o !== exp) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", got, bloco_o, exp); end
            n_cmp++; if (ksen != 68) begin n_err++; $display("FAIL b2b_ks_enable%0d: got %0d want 68", got, ksen); end
            ksen = 0;
            got++;
         end
         @(negedge clk); cyc++;
      end
      in_valid_i = 1'b0; out_ready_i = 1'b0;
      n_cmp++; if (got != 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", got); end
      n_cmp++; if (acc != 2 || acc_cyc[1] - acc_cyc[0] != 71) begin n_err++; $display("FAIL b2b_period: got acc=%0d period=%0d want 2/71", acc, acc_cyc[1] - acc_cyc[0]); end
   endtask

   task automatic test_clear;
      bit to, seen; int n = 0, cyc, ksen; logic [127:0] exp;
      drive_in({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, to);
      while (rodada_o != 7'd30 && n < 200) begin @(negedge clk); n++; end
      n_cmp++; if (rodada_o !== 7'd30) begin n_err++; $display("FAIL clr_round: got %0d want 30", rodada_o); end
      clear_i = 1'b1; @(negedge clk); clear_i = 1'b0;
      n_cmp++; if (in_ready_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0) begin n_err++; $display("FAIL clr_idle: got rdy=%b busy=%b vld=%b want 1/0/0", in_ready_o, busy_o, out_valid_o); end
      if (sb.size() > 0) void'(sb.pop_back());
      seen = 1'b0;
      repeat (80) begin @(negedge clk); if (out_valid_o) seen = 1'b1; end
      n_cmp++; if (seen) begin n_err++; $display("FAIL clr_no_output: got out_valid want none"); end
      key_i = KAT_KEY; bloco_i = KAT_BLK; in_valid_i = 1'b1; clear_i = 1'b1;
      @(negedge clk);
      in_valid_i = 1'b0; clear_i = 1'b0;
      n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL clr_blocks_accept: got busy=%b want 0", busy_o); end
      drive_in({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, to);
      wait_valid(cyc, ksen, to);
      exp = pop_exp();
      n_cmp++; if (to || bloco_o !== exp) begin n_err++; $display("FAIL clr_next_block: got %h want %h", bloco_o, exp); end
      out_ready_i = 1'b1; @(negedge clk); out_ready_i = 1'b0;
   endtask

   task automatic test_reset_mid;
      bit to; int cyc, ksen; logic [127:0] exp;
      drive_in(KAT_KEY, KAT_BLK, to);
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || busy_o !== 1'b0 || ks_enable_o !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_ctrl: got rdy=%b vld=%b busy=%b ks=%b want 1/0/0/0", in_ready_o, out_valid_o, busy_o, ks_enable_o); end
      n_cmp++; if (bloco_o !== '0 || ks_k0_o !== '0 || rodada_o !== '0) begin
         n_err++; $display("FAIL rst_mid_data: got %h/%h/%0d want 0/0/0", bloco_o, ks_k0_o, rodada_o); end
      sb.delete();
      @(negedge clk); rst_n = 1'b1;
      drive_in(KAT_KEY, KAT_BLK, to);
      wait_valid(cyc, ksen, to);
      exp = pop_exp();
      n_cmp++; if (to || cyc != 70 || bloco_o !== KAT_CT || exp !== bloco_o) begin
         n_err++; $display("FAIL rst_mid_kat: got %h lat=%0d want %h lat=70", bloco_o, cyc, KAT_CT); end
      out_ready_i = 1'b1; @(negedge clk); out_ready_i = 1'b0;
   endtask

   task automatic test_ignore_busy;
      bit to, seen; int cyc, ksen; logic [127:0] exp;
      drive_in({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, to);
      repeat (5) @(negedge clk);
      key_i = {$urandom, $urandom, $urandom, $urandom};
      bloco_i = {$urandom, $urandom, $urandom, $urandom};
      in_valid_i = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (busy_o !== 1'b1 || in_ready_o !== 1'b0) begin n_err++; $display("FAIL ign_busy: got busy=%b rdy=%b want 1/0", busy_o, in_ready_o); end
      in_valid_i = 1'b0; key_i = '0; bloco_i = '0;
      wait_valid(cyc, ksen, to);
      exp = pop_exp();
      n_cmp++; if (to || bloco_o !== exp) begin n_err++; $display("FAIL ign_data: got %h want %h", bloco_o, exp); end
      out_ready_i = 1'b1; @(negedge clk); out_ready_i = 1'b0;
      seen = 1'b0;
      repeat (80) begin @(negedge clk); if (out_valid_o || busy_o) seen = 1'b1; end
      n_cmp++; if (seen) begin n_err++; $display("FAIL ign_no_second: got extra activity want idle"); end
   endtask

   initial begin
      test_reset;
      test_kat;
      test_backpressure;
      test_back_to_back;
      test_clear;
      test_reset_mid;
      test_ignore_busy;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion want finish");
      $fatal(1, "watchdog");
   end

endmodule
